scb_update_ctrl: RTL and testbench

//  Upstream writer for the switch-control-bit (SCB) register file. Collects per-node
//  SCB updates over a valid/ready stream, merges them into a shadow copy of the current
//  SCB word, and on commit issues one single-cycle write (o_we + o_wr_data) to the file.

---
 rtl/scb_pkg.sv | 12 +
 rtl/scb_update_ctrl.sv | 72 +++++++
 tb/tb_scb_update_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/scb_pkg.sv
// scb_pkg: shared SCB geometry, FSM state type and field-offset helper
package scb_pkg;
  localparam int SCB_BLOCK_D = 128;
  localparam int SCB_BLOCK_W = $clog2(SCB_BLOCK_D);
  localparam int SCB_NODES = SCB_BLOCK_D >> 1;
  localparam int SCB_NODE_W = $clog2(SCB_NODES);
  localparam int SCB_DATA_W = SCB_NODES * SCB_BLOCK_W;
  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, WRITE} scb_state_e;
  function automatic int scb_field_lsb(input int node, input int block_w);
    return node * block_w;
  endfunction
endpackage

// File: rtl/scb_update_ctrl.sv
// scb_update_ctrl: merges per-node SCB updates into a shadow word and writes it on commit
module scb_update_ctrl
  import scb_pkg::*;
#(
  parameter int BLOCK_D = SCB_BLOCK_D,
  localparam int BLOCK_W = $clog2(BLOCK_D),
  localparam int NODES = BLOCK_D >> 1,
  localparam int NODE_W = $clog2(NODES),
  localparam int DATA_W = NODES * BLOCK_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_upd_valid,
  output logic              o_upd_ready,
  input  logic [NODE_W-1:0] i_upd_node,
  input  logic [BLOCK_W-1:0] i_upd_val,
  input  logic              i_commit_valid,
  output logic              o_commit_ready,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_we,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_done,
  output logic              o_dup_err,
  output logic              o_busy
);
  scb_state_e state, next;
  logic [DATA_W-1:0] shadow;
  logic [NODES-1:0] dirty;
  logic dup, done_q, upd_fire, commit_fire;
  assign upd_fire = o_upd_ready && i_upd_valid;
  assign commit_fire = o_commit_ready && i_commit_valid;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      shadow <= '0;
      dirty  <= '0;
      dup    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next;
      done_q <= commit_fire && next == IDLE;
      if (state == LOAD) begin
        shadow <= i_rd_data;
        dirty  <= '0;
        dup    <= 1'b0;
      end else if (upd_fire) begin
        shadow[scb_field_lsb(int'(i_upd_node), BLOCK_W) +: BLOCK_W] <= i_upd_val;
        dirty[i_upd_node] <= 1'b1;
        if (dirty[i_upd_node]) dup <= 1'b1;
      end
    end
  end
  // an update arriving with the commit makes the session non-empty even if dirty is still clear
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = i_upd_valid ? LOAD : IDLE;
      LOAD:    next = ACCUM;
      ACCUM:   if (i_commit_valid) next = (dirty != '0 || i_upd_valid) ? WRITE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    o_we           = state == WRITE;
    o_wr_data      = o_we ? shadow : '0;
    o_done         = o_we || done_q;
    o_upd_ready    = state == ACCUM;
    o_busy         = state != IDLE;
    o_dup_err      = dup;
    o_commit_ready = i_reset_n && (state == ACCUM || (state == IDLE && i_commit_valid && !i_upd_valid));
  end
endmodule

// File: tb/tb_scb_update_ctrl.sv
// tb_scb_update_ctrl: directed and randomized sessions checked against a field-array model
module tb_scb_update_ctrl;
  logic clk = 0, rst_n = 0;
  logic upd_valid = 0, commit_valid = 0;
  logic [1:0] upd_node = 0;
  logic [2:0] upd_val = 0;
  logic [11:0] rd_data = 0;
  logic upd_ready, commit_ready, we, done, dup_err, busy;
  logic [11:0] wr_data, last_wr;
  int checks = 0, passed = 0;
  int un[8], uv[8];
  always #5 clk = ~clk;
  scb_update_ctrl #(.BLOCK_D(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_upd_valid(upd_valid), .o_upd_ready(upd_ready),
    .i_upd_node(upd_node), .i_upd_val(upd_val),
    .i_commit_valid(commit_valid), .o_commit_ready(commit_ready),
    .i_rd_data(rd_data), .o_we(we), .o_wr_data(wr_data),
    .o_done(done), .o_dup_err(dup_err), .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] model_word(input logic [11:0] rd, input int n);
    int f[4];
    int w = 0;
    for (int i = 0; i < 4; i++) f[i] = (int'(rd) >> (3 * i)) % 8;
    for (int k = 0; k < n; k++) f[un[k]] = uv[k];
    for (int i = 0; i < 4; i++) w += f[i] * (1 << (3 * i));
    return 12'(w);
  endfunction
  function automatic bit model_dup(input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < k; j++)
        if (un[j] == un[k]) return 1;
    return 0;
  endfunction
  task automatic run_session(input logic [11:0] rd, input int n, input bit same_cycle);
    logic [11:0] exp_w;
    bit exp_dup;
    exp_w = model_word(rd, n);
    exp_dup = model_dup(n);
    rd_data = rd; upd_valid = 1; upd_node = 2'(un[0]); upd_val = 3'(uv[0]);
    #1 chk("idle_upd_ready", upd_ready, 0);
    tick;
    #1 chk("load_upd_ready", upd_ready, 0);
    chk("load_busy", busy, 1);
    tick;
    rd_data = 12'($urandom);
    #1 chk("accum_dup_cleared", dup_err, 0);
    for (int k = 0; k < n; k++) begin
      upd_node = 2'(un[k]); upd_val = 3'(uv[k]);
      commit_valid = same_cycle && k == n - 1;
      #1 chk("accum_upd_ready", upd_ready, 1);
      tick;
    end
    if (!same_cycle) begin
      upd_valid = 0; commit_valid = 1;
      #1 chk("accum_commit_ready", commit_ready, 1);
      tick;
    end
    upd_valid = 0; commit_valid = 0;
    #1 chk("write_we", we, 1);
    chk("write_data", wr_data, exp_w);
    chk("write_done", done, 1);
    chk("write_dup", dup_err, exp_dup);
    last_wr = wr_data;
    tick;
    #1 chk("post_we", we, 0);
    chk("post_data", wr_data, 0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_dup_hold", dup_err, exp_dup);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dup", dup_err, 0);
    chk("rst_data", wr_data, 0);
    rst_n = 1;
    tick;
    un[0] = 1; uv[0] = 2;
    run_session(12'hFFF, 1, 0);
    chk("t1_word", last_wr, 12'hFD7);
    un[0] = 0; uv[0] = 1; un[1] = 3; uv[1] = 5; un[2] = 0; uv[2] = 6;
    run_session(12'hFFF, 3, 0);
    chk("t2_word", last_wr, 12'hBFE);
    chk("t2_dup", dup_err, 1);
    commit_valid = 1;
    #1 chk("t3_commit_ready", commit_ready, 1);
    chk("t3_we", we, 0);
    tick;
    commit_valid = 0;
    #1 chk("t3_done", done, 1);
    chk("t3_no_we", we, 0);
    chk("t3_dup_hold", dup_err, 1);
    tick;
    #1 chk("t3_done_end", done, 0);
    chk("t3_no_we_end", we, 0);
    un[0] = 2; uv[0] = 7;
    run_session(12'h000, 1, 1);
    chk("t4_word", last_wr, 12'h1C0);
    upd_valid = 1;
    tick;
    upd_valid = 0;
    tick;
    commit_valid = 1;
    #1 chk("empty_commit_ready", commit_ready, 1);
    tick;
    commit_valid = 0;
    #1 chk("empty_done", done, 1);
    chk("empty_no_we", we, 0);
    chk("empty_idle", busy, 0);
    tick;
    #1 chk("empty_done_end", done, 0);
    upd_valid = 1; upd_node = 1; upd_val = 3; rd_data = 12'h5A5;
    tick;
    tick;
    tick;
    upd_node = 3; upd_val = 4;
    tick;
    upd_valid = 0;
    #2 rst_n = 0;
    #1 chk("t5_we", we, 0);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_upd_ready", upd_ready, 0);
    chk("t5_commit_ready", commit_ready, 0);
    chk("t5_dup", dup_err, 0);
    tick;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("t5_after_we", we, 0);
      chk("t5_after_done", done, 0);
      chk("t5_after_busy", busy, 0);
    end
    for (int s = 0; s < 25; s++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        un[k] = $urandom_range(0, 3);
        uv[k] = $urandom_range(0, 7);
      end
      run_session(12'($urandom), n, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
